// File: rtl/mem_ctrl.sv
// Single-port byte-RAM controller arbitrating instruction fetch and load/store.
// Reads are assembled little-endian into 32-bit words; stores are written byte by byte.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_readwrite,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [1:0]        if_status,
  output logic [DATA_W-1:0] if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_status,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              r_state, w_state_next;
  logic                r_owner_mem, w_owner_mem_next;
  logic [1:0]          r_k, w_k_next;
  logic [1:0]          r_last_k, w_last_k_next;
  logic                r_issued, w_issued_next;
  logic                r_pend, w_pend_next;
  logic [1:0]          r_pend_k, w_pend_k_next;
  logic                r_reread, w_reread_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [DATA_W-1:0]   r_wdata, w_wdata_next;
  logic [DATA_W-1:0]   r_buf, w_buf_next;
  logic [ADDR_W-1:0]   r_ram_a, w_ram_a_next;
  logic [7:0]          r_ram_dout, w_ram_dout_next;
  logic                r_ram_wr, w_ram_wr_next;
  logic [DATA_W-1:0]   r_if_data, w_if_data_next;
  logic [DATA_W-1:0]   r_mem_rdata, w_mem_rdata_next;
  logic [1:0]          w_code;
  logic [1:0]          w_k_inc;
  logic [1:0]          w_len_last;

  assign w_k_inc    = r_k + 2'd1;
  assign w_len_last = (mem_len == 2'd0) ? 2'd0 : (mem_len == 2'd1) ? 2'd1 : 2'd3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (rdy) begin
      case (r_state)
        IDLE:    if (mem_req)           w_state_next = mem_we ? WRITE : READ;
                 else if (if_readwrite) w_state_next = READ;
        READ:    if (!r_reread && r_issued) w_state_next = DONE;
        WRITE:   if (r_k == r_last_k)   w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_owner_mem_next = r_owner_mem;
    w_k_next         = r_k;
    w_last_k_next    = r_last_k;
    w_issued_next    = r_issued;
    w_pend_next      = r_pend;
    w_pend_k_next    = r_pend_k;
    w_reread_next    = r_reread;
    w_addr_next      = r_addr;
    w_wdata_next     = r_wdata;
    w_buf_next       = r_buf;
    w_ram_a_next     = r_ram_a;
    w_ram_dout_next  = r_ram_dout;
    w_ram_wr_next    = r_ram_wr;
    w_if_data_next   = r_if_data;
    w_mem_rdata_next = r_mem_rdata;
    case (r_state)
      IDLE: if (rdy && (mem_req || if_readwrite)) begin
        w_owner_mem_next = mem_req;
        w_addr_next      = mem_req ? mem_addr : if_addr;
        w_wdata_next     = mem_wdata;
        w_last_k_next    = mem_req ? w_len_last : 2'd3;
        w_k_next         = 2'd0;
        w_issued_next    = 1'b0;
        w_pend_next      = 1'b0;
        w_reread_next    = 1'b0;
        w_buf_next       = '0;
        w_ram_a_next     = mem_req ? mem_addr : if_addr;
        w_ram_wr_next    = mem_req && mem_we;
        if (mem_req && mem_we) w_ram_dout_next = mem_wdata[7:0];
      end
      READ: begin
        // A byte arriving while frozen is lost; flag it so the address is re-driven on resume.
        if (!rdy) w_reread_next = r_reread || r_pend;
        else if (r_reread) w_reread_next = 1'b0;
        else begin
          if (r_pend) w_buf_next[{r_pend_k, 3'b000} +: 8] = ram_din;
          if (!r_issued) begin
            w_pend_next   = 1'b1;
            w_pend_k_next = r_k;
            if (r_k == r_last_k) w_issued_next = 1'b1;
            else begin
              w_k_next     = w_k_inc;
              w_ram_a_next = r_ram_a + 1'b1;
            end
          end else begin
            w_pend_next = 1'b0;
            if (r_owner_mem) w_mem_rdata_next = w_buf_next;
            else             w_if_data_next   = w_buf_next;
          end
        end
      end
      WRITE: if (rdy) begin
        if (r_k == r_last_k) w_ram_wr_next = 1'b0;
        else begin
          w_k_next        = w_k_inc;
          w_ram_a_next    = r_ram_a + 1'b1;
          w_ram_dout_next = r_wdata[{w_k_inc, 3'b000} +: 8];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner_mem <= 1'b0;
      r_k         <= '0;
      r_last_k    <= '0;
      r_issued    <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_k    <= '0;
      r_reread    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_ram_a     <= '0;
      r_ram_dout  <= '0;
      r_ram_wr    <= 1'b0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_owner_mem <= w_owner_mem_next;
      r_k         <= w_k_next;
      r_last_k    <= w_last_k_next;
      r_issued    <= w_issued_next;
      r_pend      <= w_pend_next;
      r_pend_k    <= w_pend_k_next;
      r_reread    <= w_reread_next;
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
      r_buf       <= w_buf_next;
      r_ram_a     <= w_ram_a_next;
      r_ram_dout  <= w_ram_dout_next;
      r_ram_wr    <= w_ram_wr_next;
      r_if_data   <= w_if_data_next;
      r_mem_rdata <= w_mem_rdata_next;
    end
  end

  always_comb begin
    if_status  = 2'b00;
    mem_status = 2'b00;
    case (r_state)
      READ, WRITE: w_code = 2'b01;
      DONE:        w_code = 2'b10;
      default:     w_code = 2'b00;
    endcase
    if (r_owner_mem) mem_status = w_code;
    else             if_status  = w_code;
  end

  assign if_data   = r_if_data;
  assign mem_rdata = r_mem_rdata;
  assign ram_dout  = r_ram_dout;
  assign ram_wr    = r_ram_wr && rdy;
  assign ram_a     = (r_reread && rdy) ? (r_addr + ADDR_W'(r_pend_k)) : r_ram_a;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model with one-cycle read latency and a
// scoreboard queue of expected read words popped whenever a requester sees Done.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        if_readwrite = 1'b0;
  logic [31:0] if_addr = '0;
  logic [1:0]  if_status;
  logic [31:0] if_data;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [1:0]  mem_len = '0;
  logic [31:0] mem_wdata = '0;
  logic [1:0]  mem_status;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din = '0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ram [logic [31:0]];

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_readwrite(if_readwrite), .if_addr(if_addr), .if_status(if_status), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_status(mem_status), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  always @(posedge clk) ram_din <= ram_rd(ram_a);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_done(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {32'h0, obs}, {32'h0, e});
    end
  endtask

  initial begin
    ram[32'h1004] = 8'h13; ram[32'h1005] = 8'h05; ram[32'h1006] = 8'h00; ram[32'h1007] = 8'h00;
    ram[32'h20] = 8'h11; ram[32'h21] = 8'h22; ram[32'h22] = 8'h33; ram[32'h23] = 8'h44;
    ram[32'h40] = 8'h80; ram[32'h41] = 8'hFF;
    ram[32'h50] = 8'hA1; ram[32'h51] = 8'hB2; ram[32'h52] = 8'hC3; ram[32'h53] = 8'hD4;

    // Reset state
    #3;
    chk("rst_if_status", {62'h0, if_status}, 64'h0);
    chk("rst_mem_status", {62'h0, mem_status}, 64'h0);
    chk("rst_ram_a", {32'h0, ram_a}, 64'h0);
    chk("rst_ram_wr", {63'h0, ram_wr}, 64'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_idle", {62'h0, if_status}, 64'h0);
    $display("reset: done");

    // Fetch 0x1004 -> 0x00000513
    exp_q.push_back(32'h0000_0513);
    if_addr = 32'h1004; if_readwrite = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("fetch_wr", {63'h0, ram_wr}, 64'h0);
      if (i <= 4) chk("fetch_ram_a", {32'h0, ram_a}, {32'h0, 32'h1004 + 32'(i - 1)});
      if (i <= 5) chk("fetch_busy", {62'h0, if_status}, 64'h1);
      if (i == 6) begin
        chk("fetch_done", {62'h0, if_status}, 64'h2);
        chk_done("fetch_data", if_data);
        if_readwrite = 1'b0;
      end
      if (i == 7) chk("fetch_idle", {62'h0, if_status}, 64'h0);
    end
    $display("fetch 0x1004: if_data=%h", if_data);

    // Store half 0xABCD at 0xFFFFFFFF (wraps to 0x0)
    mem_addr = 32'hFFFF_FFFF; mem_we = 1'b1; mem_len = 2'd1; mem_wdata = 32'h1234_ABCD; mem_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) begin
        chk("st_wr1", {63'h0, ram_wr}, 64'h1);
        chk("st_a1", {32'h0, ram_a}, 64'hFFFF_FFFF);
        chk("st_d1", {56'h0, ram_dout}, 64'hCD);
      end
      if (i == 2) begin
        chk("st_wr2", {63'h0, ram_wr}, 64'h1);
        chk("st_a2", {32'h0, ram_a}, 64'h0);
        chk("st_d2", {56'h0, ram_dout}, 64'hAB);
      end
      if (i <= 2) chk("st_busy", {62'h0, mem_status}, 64'h1);
      if (i == 3) begin
        chk("st_done", {62'h0, mem_status}, 64'h2);
        chk("st_done_wr", {63'h0, ram_wr}, 64'h0);
        mem_req = 1'b0; mem_we = 1'b0;
      end
      if (i == 4) chk("st_idle", {62'h0, mem_status}, 64'h0);
    end
    $display("store half 0xABCD @0xFFFFFFFF: done");

    // Simultaneous requests: load word 0x20 first, then fetch
    exp_q.push_back(32'h4433_2211);
    exp_q.push_back(32'h0000_0513);
    mem_addr = 32'h20; mem_len = 2'd2; mem_req = 1'b1;
    if_addr = 32'h1004; if_readwrite = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk("arb_wr", {63'h0, ram_wr}, 64'h0);
      if (i <= 5) chk("arb_mem_busy", {62'h0, mem_status}, 64'h1);
      if (i == 6) begin
        chk("arb_mem_done", {62'h0, mem_status}, 64'h2);
        chk_done("arb_mem_data", mem_rdata);
        mem_req = 1'b0;
      end
      if (i >= 7) chk("arb_mem_idle", {62'h0, mem_status}, 64'h0);
      if (i <= 7) chk("arb_if_init", {62'h0, if_status}, 64'h0);
      if (i == 8) chk("arb_if_ram_a", {32'h0, ram_a}, 64'h1004);
      if (i >= 8 && i <= 12) chk("arb_if_busy", {62'h0, if_status}, 64'h1);
      if (i == 13) begin
        chk("arb_if_done", {62'h0, if_status}, 64'h2);
        chk_done("arb_if_data", if_data);
        if_readwrite = 1'b0;
      end
      if (i == 14) chk("arb_if_idle", {62'h0, if_status}, 64'h0);
    end
    $display("arbitration: mem_rdata=%h if_data=%h", mem_rdata, if_data);

    // Byte load 0x80, zero-extended
    exp_q.push_back(32'h0000_0080);
    mem_addr = 32'h40; mem_len = 2'd0; mem_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) chk("lb_ram_a", {32'h0, ram_a}, 64'h40);
      if (i <= 2) chk("lb_busy", {62'h0, mem_status}, 64'h1);
      if (i == 3) begin
        chk("lb_done", {62'h0, mem_status}, 64'h2);
        chk_done("lb_data", mem_rdata);
        mem_req = 1'b0;
      end
      if (i == 4) chk("lb_idle", {62'h0, mem_status}, 64'h0);
    end
    $display("byte load 0x40: mem_rdata=%h", mem_rdata);

    // Word load at 0x50 with rdy low during C+2 and C+3
    exp_q.push_back(32'hD4C3_B2A1);
    mem_addr = 32'h50; mem_len = 2'd2; mem_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 2) rdy = 1'b0;
      if (i == 4) rdy = 1'b1;
      #1;
      chk("rdy_wr", {63'h0, ram_wr}, 64'h0);
      if (i == 2 || i == 3) chk("rdy_hold_a", {32'h0, ram_a}, 64'h51);
      if (i == 4) chk("rdy_reread_a", {32'h0, ram_a}, 64'h50);
      if (i == 5) chk("rdy_resume_a", {32'h0, ram_a}, 64'h51);
      if (i <= 8) chk("rdy_busy", {62'h0, mem_status}, 64'h1);
      if (i == 9) begin
        chk("rdy_done", {62'h0, mem_status}, 64'h2);
        chk_done("rdy_data", mem_rdata);
        mem_req = 1'b0;
      end
      if (i == 10) chk("rdy_idle", {62'h0, mem_status}, 64'h0);
    end
    $display("rdy freeze load 0x50: mem_rdata=%h", mem_rdata);

    // Reset in the middle of a fetch
    if_addr = 32'h1004; if_readwrite = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("mrst_if_status", {62'h0, if_status}, 64'h0);
    chk("mrst_if_data", {32'h0, if_data}, 64'h0);
    chk("mrst_mem_rdata", {32'h0, mem_rdata}, 64'h0);
    chk("mrst_ram_a", {32'h0, ram_a}, 64'h0);
    chk("mrst_ram_dout", {56'h0, ram_dout}, 64'h0);
    chk("mrst_ram_wr", {63'h0, ram_wr}, 64'h0);
    if_readwrite = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("mrst_no_done", {62'h0, if_status}, 64'h0);
    end
    chk("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("reset mid-fetch: if_status=%b", if_status);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory controller between the byte-wide RAM and the two CPU requesters: the instruction-fetch stage and the load/store stage.
- Serves one request at a time.
- Assembles reads into 32-bit little-endian words and serialises stores byte by byte.
- Reports progress to each requester through a 2-bit status code: Init/Busy/Done.

Parameters:
- ADDR_W, 32, address width of requester and RAM addresses.
- DATA_W, 32, requester data width; fixed at 4 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- rdy  in  1  global enable; 0 freezes the block.
- if_readwrite  in  1  fetch request, level-held until Done.
- if_addr  in  ADDR_W  fetch address, word-aligned.
- if_status  out  2  fetch status: 00 Init, 01 Busy, 10 Done.
- if_data  out  32  fetched instruction; valid while if_status=Done.
- mem_req  in  1  load/store request, level-held until Done.
- mem_we  in  1  1=store, 0=load.
- mem_addr  in  ADDR_W  byte address.
- mem_len  in  2  access size: 0 byte, 1 half, 2 word; 3 is treated as word.
- mem_wdata  in  32  store data, low bytes used.
- mem_status  out  2  load/store status, same encoding as if_status.
- mem_rdata  out  32  load data, zero-extended; valid while mem_status=Done.
- ram_din  in  8  RAM read byte; returned one cycle after ram_a.
- ram_dout  out  8  RAM write byte.
- ram_a  out  ADDR_W  RAM byte address.
- ram_wr  out  1  RAM write strobe.

Behaviour:
- Reset (rst=0, asynchronous) clears all outputs: if_status=00, mem_status=00, if_data=0, mem_rdata=0, ram_a=0, ram_dout=0, ram_wr=0; FSM goes to IDLE.
- Reset mid-transaction abandons the transaction; no Done is issued for it.
- FSM states: IDLE, READ, WRITE, DONE. Internal state: byte counter k (0..3), length N (1/2/4), owner flag (IF or MEM).
- IDLE, accept cycle C: request sampled.
  - mem_req has priority over if_readwrite when both are high.
  - Addresses, length, wdata and owner are latched.
  - Goes to READ (load or fetch) or WRITE (store).
  - The owner's status is Busy from C+1.
  - The non-owner stays Init throughout, even if its request is high.
- READ:
  - ram_a = addr+k in cycles C+1..C+N.
  - ram_din is captured into byte lane k one cycle later, in cycles C+2..C+N+1.
  - Done is asserted in cycle C+N+2 with the assembled data. Fetch: N=4, so Done at C+6.
- WRITE:
  - ram_wr=1 with ram_a=addr+k and ram_dout=wdata[8k+7:8k] in cycles C+1..C+N.
  - Done is asserted at C+N+1 with ram_wr=0.
- DONE:
  - The owner's status is 10 for exactly one cycle; data is stable that cycle.
  - Next state is IDLE.
  - A request still high in the cycle after Done starts a new transaction; there is no back-to-back skip.
- Address arithmetic is addr+k modulo 2^ADDR_W; wrap-around is permitted.
- Unused upper bytes of mem_rdata are 0; sign extension belongs to the load/store stage.
- rdy=0:
  - State, counter, ram_a and captured data hold.
  - ram_wr is forced to 0.
  - A RAM byte returned during the frozen cycle is re-read after resume, so ram_a is re-driven for one cycle before counting continues.
- Requester inputs may change after the accept cycle; latched copies are used.
- A requester dropping its request mid-transaction does not abort it; Done is still issued.
- ram_wr is never high in READ, IDLE or DONE.

Test Plan:
- Reset mid-fetch: rst low at C+3 -> all outputs 0 immediately; after release with no request, if_status=00.
- Fetch 0x00001004, RAM bytes 13,05,00,00 -> ram_a 0x1004..0x1007 at C+1..C+4; if_status=01 for C+1..C+5; Done at C+6 with if_data=0x00000513, then 00.
- Simultaneous if_readwrite and mem_req (load word at 0x20) -> load served first, if_status stays 00; fetch accepted the cycle after mem Done.
- Store half 0xABCD at 0xFFFFFFFF -> ram_wr at C+1 (a=0xFFFFFFFF, dout=CD) and C+2 (a=0x0, dout=AB); mem_status Done at C+3.
- Byte load, RAM byte 0x80 -> mem_rdata=0x00000080, Done at C+3.
- rdy low for 2 cycles during word read -> no lost or duplicated bytes; Done delayed by exactly 3 cycles (2 frozen + 1 re-read), data correct; ram_wr stays 0.
